pim_weight_loader: RTL and testbench
====================================

// Module: pim_weight_loader
// PURPOSE
//  Parametrised, double-buffered weight row loader for the PIM macro wrapper.
//  - Accepts DATA_W-bit bus beats over a valid/ready handshake, with an internal beat counter.
//  - De-interleaves each beat nibble-wise into a CAM half-row and a CIM half-row.
//  - Presents each completed row on a registered valid/ready output while the next row fills.
// PARAMETERS
//  DATA_W  32  input beat width; must be a multiple of 2*LANE_W
//  LANE_W  4   nibble (lane) width; upper lane of each pair -> CAM, lower -> CIM
//  BEATS   16  beats per row; ROW_W = BEATS*DATA_W/2 (256 at defaults)
//  CNT_W   $clog2(BEATS)  beat counter width
// PORTS
//  i_clk         in   1       clock
//  i_rst_n       in   1       asynchronous reset, active low
//  i_clear       in   1       synchronous flush of fill and hold banks
//  i_in_valid    in   1       input beat valid
//  o_in_ready    out  1       loader can accept a beat
//  i_in_data     in   DATA_W  input beat
//  i_in_last     in   1       marks last beat of a row (framing check)
//  o_out_valid   out  1       hold bank holds a complete row
//  i_out_ready   in   1       macro consumes the row
//  o_cam_data    out  ROW_W   CAM half-row (registered)
//  o_cim_data    out  ROW_W   CIM half-row (registered)
//  o_beat_cnt    out  CNT_W   beats accepted into current fill row
//  o_err_frame   out  1       sticky framing error
// BEHAVIOUR
//  - Clock and reset: one clock, i_clk. Reset is asynchronous and active-low (i_rst_n).
//  - Reset values: fill FSM=S_FILL, hold valid=0, o_cam_data=o_cim_data=0, o_beat_cnt=0, o_err_frame=0.
//  - o_in_ready is low while i_rst_n=0 and in S_STALL; it is high in S_FILL, including the first cycle after reset release.
//  - Beat accept: i_in_valid && o_in_ready. Beat k (0..BEATS-1) writes fill bits [ROW_W-1-k*H -: H], with H=DATA_W/2.
//  - Split: within each 2*LANE_W group, taken MSB first, the upper LANE_W bits go to CAM and the lower LANE_W bits go to CIM.
//    Example: 32'h12345678 -> CAM 16'h1357, CIM 16'h2468.
//  - Row complete: beat BEATS-1 is accepted. Next cycle the fill bank is copied to the hold regs, o_out_valid=1, and the counter wraps to 0.
//    Latency from last beat to valid is 1 cycle.
//  - If the hold bank is valid and not draining this cycle, the FSM goes to S_STALL (in_ready=0). The full fill bank is kept.
//  - S_STALL -> S_FILL: on the cycle the hold bank drains, fill is copied to hold and o_out_valid stays 1 with the new row.
//  - Simultaneous completion and drain: the hold bank reloads the same cycle; o_out_valid remains 1 with no bubble.
//  - Output transfer: o_out_valid && i_out_ready. o_cam_data/o_cim_data are held stable while valid && !ready.
//    After drain with nothing pending, o_out_valid=0 and the data regs keep their last value.
//  - Framing, early last (i_in_last accepted with cnt<BEATS-1): o_err_frame=1, the partial row is discarded, cnt returns to 0.
//  - Framing, missing last (beat BEATS-1 accepted without last): o_err_frame=1, but the row still completes normally.
//  - i_clear: has priority over both handshakes. Next cycle cnt=0, hold valid=0, FSM=S_FILL, o_err_frame=0; data regs are not zeroed.
//  - Async reset asserted mid-row or mid-stall: all state and outputs go to reset values immediately, without a clock edge.
// STRUCTURE
//  - pim_wrap_pkg holds LANE_W default, ROW_W/H derivation functions, and the FSM state encoding (S_FILL, S_STALL).
//  - Sub-module pim_nibble_split: combinational DATA_W -> two DATA_W/2 de-interleave, parametrised on DATA_W and LANE_W.
//  - The top level holds the fill bank, hold regs, beat counter, FSM and error flag.
// TESTING
//  1. Reset, then 16 beats: beat0=32'h12345678, the rest 0, last on beat 15.
//     -> o_out_valid one cycle later; CAM[255:240]=16'h1357, CIM[255:240]=16'h2468; all other bits 0.
//  2. i_out_ready=0 while 33 beats are offered.
//     -> Row 1 is held stable. o_in_ready=0 after beat 32 is accepted; beat 33 stalls.
//     -> A ready pulse of 1 cycle delivers row 1, then row 2 is valid next cycle and o_in_ready=1.
//  3. Hold bank draining on the same cycle the beat-15 of the next row is accepted.
//     -> o_out_valid stays 1, data switches to the new row, no stall.
//  4. i_in_last asserted on beat 5.
//     -> o_err_frame=1, no o_out_valid, o_beat_cnt=0. The next 16 clean beats give a correct row.
//  5. i_clear at beat 7 while the hold bank is valid.
//     -> Next cycle o_out_valid=0, o_beat_cnt=0, o_err_frame=0, o_in_ready=1.
//  6. i_rst_n pulsed low between clock edges in S_STALL.
//     -> Outputs are 0 immediately. Rerun test 1 with BEATS=4, DATA_W=64 (ROW_W=128) to check parametrisation.

Source files
------------

// File: rtl/pim_wrap_pkg.sv
// Shared definitions for the PIM macro wrapper: lane width default, row geometry
// helpers and the weight-loader fill FSM encoding.
package pim_wrap_pkg;

    localparam int LANE_W_DEF = 4;

    typedef enum logic {
        S_FILL  = 1'b0,
        S_STALL = 1'b1
    } fill_state_e;

    function automatic int half_w(input int data_w);
        return data_w / 2;
    endfunction

    // Each beat contributes half its width to each of the CAM and CIM rows.
    function automatic int row_w(input int beats, input int data_w);
        return beats * half_w(data_w);
    endfunction

endpackage

// File: rtl/pim_nibble_split.sv
// Combinational de-interleave of one bus beat: within each lane pair the upper
// lane goes to the CAM half, the lower lane to the CIM half, order preserved.
module pim_nibble_split #(
    parameter int DATA_W = 32,
    parameter int LANE_W = 4
) (
    input  logic [DATA_W-1:0]   data,
    output logic [DATA_W/2-1:0] cam,
    output logic [DATA_W/2-1:0] cim
);
    localparam int PAIRS = DATA_W / (2 * LANE_W);

    for (genvar g = 0; g < PAIRS; g++) begin : g_pair
        assign cam[g*LANE_W +: LANE_W] = data[g*2*LANE_W + LANE_W +: LANE_W];
        assign cim[g*LANE_W +: LANE_W] = data[g*2*LANE_W +: LANE_W];
    end

endmodule

// File: rtl/pim_weight_loader.sv
// Double-buffered weight row loader: beats fill a row bank while the previous
// complete row is presented on a registered valid/ready output.
module pim_weight_loader
    import pim_wrap_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int LANE_W = LANE_W_DEF,
    parameter  int BEATS  = 16,
    parameter  int CNT_W  = $clog2(BEATS),
    localparam int H      = half_w(DATA_W),
    localparam int ROW_W  = row_w(BEATS, DATA_W)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic              i_in_last,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [ROW_W-1:0]  o_cam_data,
    output logic [ROW_W-1:0]  o_cim_data,
    output logic [CNT_W-1:0]  o_beat_cnt,
    output logic              o_err_frame
);
    fill_state_e             state, state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic                    hold_vld;
    logic                    err;
    logic [BEATS-1:0][H-1:0] fill_cam, fill_cim;
    logic [ROW_W-1:0]        hold_cam, hold_cim;
    logic [H-1:0]            beat_cam, beat_cim;
    logic                    accept, drain, last_beat, early, load_hold;

    pim_nibble_split #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W)
    ) u_split (
        .data (i_in_data),
        .cam  (beat_cam),
        .cim  (beat_cim)
    );

    assign o_in_ready = i_rst_n && (state == S_FILL);
    assign accept     = i_in_valid && o_in_ready;
    assign drain      = hold_vld && i_out_ready;
    assign last_beat  = (cnt == CNT_W'(BEATS - 1));
    assign early      = accept && i_in_last && !last_beat;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_FILL;
        else          state <= state_nxt;
    end

    // A completed row goes straight to the hold regs when they are free or
    // draining this cycle; otherwise it parks in the fill bank until they are.
    always_comb begin
        state_nxt = state;
        load_hold = 1'b0;
        if (i_clear) begin
            state_nxt = S_FILL;
        end else begin
            case (state)
                S_FILL: begin
                    if (accept && last_beat) begin
                        if (!hold_vld || drain) load_hold = 1'b1;
                        else                    state_nxt = S_STALL;
                    end
                end
                S_STALL: begin
                    if (drain) begin
                        load_hold = 1'b1;
                        state_nxt = S_FILL;
                    end
                end
                default: state_nxt = S_FILL;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt      <= '0;
            hold_vld <= 1'b0;
            err      <= 1'b0;
            fill_cam <= '0;
            fill_cim <= '0;
            hold_cam <= '0;
            hold_cim <= '0;
        end else if (i_clear) begin
            cnt      <= '0;
            hold_vld <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (accept) begin
                cnt <= (last_beat || early) ? '0 : cnt + CNT_W'(1);
                if (early || (last_beat && !i_in_last)) err <= 1'b1;
            end
            // Beat k lands in the k-th slot from the top of the row.
            if (accept && !early) begin
                for (int k = 0; k < BEATS; k++) begin
                    if (cnt == CNT_W'(k)) begin
                        fill_cam[BEATS-1-k] <= beat_cam;
                        fill_cim[BEATS-1-k] <= beat_cim;
                    end
                end
            end
            if (load_hold) begin
                hold_vld <= 1'b1;
                if (state == S_FILL) begin
                    hold_cam <= {fill_cam[BEATS-1:1], beat_cam};
                    hold_cim <= {fill_cim[BEATS-1:1], beat_cim};
                end else begin
                    hold_cam <= fill_cam;
                    hold_cim <= fill_cim;
                end
            end else if (drain) begin
                hold_vld <= 1'b0;
            end
        end
    end

    assign o_out_valid = hold_vld;
    assign o_cam_data  = hold_cam;
    assign o_cim_data  = hold_cim;
    assign o_beat_cnt  = cnt;
    assign o_err_frame = err;

endmodule

// File: tb/tb_pim_weight_loader.sv
// Directed bench for pim_weight_loader: a row-queue model checked every cycle,
// plus literal expectations per scenario and a second, re-parametrised instance.
module tb_pim_weight_loader;
    localparam int DATA_W = 32;
    localparam int BEATS  = 16;
    localparam int ROW_W  = 256;
    localparam int H      = 16;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b1;
    logic              i_clear = 1'b0;
    logic              i_in_valid = 1'b0;
    logic              o_in_ready;
    logic [DATA_W-1:0] i_in_data = '0;
    logic              i_in_last = 1'b0;
    logic              o_out_valid;
    logic              i_out_ready = 1'b0;
    logic [ROW_W-1:0]  o_cam_data, o_cim_data;
    logic [3:0]        o_beat_cnt;
    logic              o_err_frame;

    logic          b_in_valid = 1'b0;
    logic          b_in_ready;
    logic [63:0]   b_in_data = '0;
    logic          b_in_last = 1'b0;
    logic          b_out_valid;
    logic [127:0]  b_cam, b_cim;
    logic [1:0]    b_cnt;
    logic          b_err;

    always #5 i_clk = ~i_clk;

    pim_weight_loader u_dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
        .i_in_last(i_in_last), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_cam_data(o_cam_data), .o_cim_data(o_cim_data), .o_beat_cnt(o_beat_cnt),
        .o_err_frame(o_err_frame)
    );

    pim_weight_loader #(.DATA_W(64), .BEATS(4)) u_dut2 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(1'b0),
        .i_in_valid(b_in_valid), .o_in_ready(b_in_ready), .i_in_data(b_in_data),
        .i_in_last(b_in_last), .o_out_valid(b_out_valid), .i_out_ready(1'b0),
        .o_cam_data(b_cam), .o_cim_data(b_cim), .o_beat_cnt(b_cnt),
        .o_err_frame(b_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Odd nibbles (upper of each pair) form the CAM half, even nibbles the CIM half.
    function automatic logic [H-1:0] cam_of(input logic [31:0] d);
        logic [H-1:0] r = '0;
        for (int g = 7; g >= 1; g -= 2) r = {r[11:0], d[g*4 +: 4]};
        return r;
    endfunction

    function automatic logic [H-1:0] cim_of(input logic [31:0] d);
        logic [H-1:0] r = '0;
        for (int g = 6; g >= 0; g -= 2) r = {r[11:0], d[g*4 +: 4]};
        return r;
    endfunction

    // Model: completed rows wait in a queue of depth 2 (presented + parked).
    typedef struct packed {
        logic [ROW_W-1:0] cam;
        logic [ROW_W-1:0] cim;
    } row_t;

    row_t             q[$];
    int               m_cnt = 0;
    bit               m_err = 1'b0;
    logic [ROW_W-1:0] cur_cam = '0, cur_cim = '0;
    logic [ROW_W-1:0] m_cam = '0, m_cim = '0;

    initial forever begin
        @(posedge i_clk or negedge i_rst_n);
        if (!i_rst_n) begin
            q.delete();
            m_cnt = 0; m_err = 1'b0; m_cam = '0; m_cim = '0;
        end else if (i_clear) begin
            q.delete();
            m_cnt = 0; m_err = 1'b0;
        end else begin
            bit acc;
            acc = i_in_valid && (q.size() < 2);
            if (q.size() > 0 && i_out_ready) void'(q.pop_front());
            if (acc) begin
                cur_cam = {cur_cam[ROW_W-H-1:0], cam_of(i_in_data)};
                cur_cim = {cur_cim[ROW_W-H-1:0], cim_of(i_in_data)};
                if (i_in_last && m_cnt < BEATS - 1) begin
                    m_err = 1'b1; m_cnt = 0;
                end else if (m_cnt == BEATS - 1) begin
                    if (!i_in_last) m_err = 1'b1;
                    q.push_back('{cam: cur_cam, cim: cur_cim});
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
            if (q.size() > 0) begin
                m_cam = q[0].cam; m_cim = q[0].cim;
            end
        end
    end

    initial forever begin
        @(negedge i_clk);
        if (i_rst_n) begin
            check("mdl_in_ready", 256'(o_in_ready), 256'(q.size() < 2));
            check("mdl_out_valid", 256'(o_out_valid), 256'(q.size() > 0));
            check("mdl_beat_cnt", 256'(o_beat_cnt), 256'(m_cnt));
            check("mdl_err_frame", 256'(o_err_frame), 256'(m_err));
            check("mdl_cam", 256'(o_cam_data), 256'(m_cam));
            check("mdl_cim", 256'(o_cim_data), 256'(m_cim));
        end
    end

    // Presents one beat from a negedge; returns at the negedge after it is taken.
    task automatic send_beat(input logic [31:0] d, input logic last);
        int n = 0;
        i_in_valid = 1'b1; i_in_data = d; i_in_last = last;
        while (!o_in_ready && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 50) begin
            errors++; checks++;
            $display("FAIL beat_accept_timeout: in_ready stayed 0 for %0d cycles", n);
        end
        @(negedge i_clk);
        i_in_valid = 1'b0; i_in_last = 1'b0;
    endtask

    task automatic send_row(input logic [31:0] b0, input logic [31:0] rest);
        for (int k = 0; k < BEATS; k++) send_beat(k == 0 ? b0 : rest, k == BEATS - 1);
    endtask

    task automatic pulse_out_ready(input int n);
        i_out_ready = 1'b1;
        repeat (n) @(negedge i_clk);
        i_out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #1 i_rst_n = 1'b0;
        #2;
        check("rst_in_ready", 256'(o_in_ready), 256'(0));
        check("rst_out_valid", 256'(o_out_valid), 256'(0));
        check("rst_cnt", 256'(o_beat_cnt), 256'(0));
        check("rst_cam", 256'(o_cam_data), 256'(0));
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1 check("rel_in_ready", 256'(o_in_ready), 256'(1));
        @(negedge i_clk);

        // Single row, only beat 0 non-zero
        send_row(32'h12345678, 32'h0);
        check("t1_valid", 256'(o_out_valid), 256'(1));
        check("t1_cam", 256'(o_cam_data), {16'h1357, 240'h0});
        check("t1_cim", 256'(o_cim_data), {16'h2468, 240'h0});
        pulse_out_ready(1);
        check("t1_drained", 256'(o_out_valid), 256'(0));

        // Back-pressure: two rows fill, the next beat stalls
        for (int r = 1; r <= 2; r++)
            for (int k = 0; k < BEATS; k++) send_beat(32'hA500_0000 | (r << 16) | k, k == BEATS - 1);
        check("t2_stall_ready", 256'(o_in_ready), 256'(0));
        check("t2_row1_cam", 256'(o_cam_data[255:224]), 256'({cam_of(32'hA501_0000), cam_of(32'hA501_0001)}));
        i_in_valid = 1'b1; i_in_data = 32'hA503_0000; i_in_last = 1'b0;
        repeat (3) @(negedge i_clk);
        check("t2_beat33_held", 256'(o_beat_cnt), 256'(0));
        pulse_out_ready(1);
        check("t2_row2_valid", 256'(o_out_valid), 256'(1));
        check("t2_ready_back", 256'(o_in_ready), 256'(1));
        check("t2_row2_cam", 256'(o_cam_data[255:224]), 256'({cam_of(32'hA502_0000), cam_of(32'hA502_0001)}));
        @(negedge i_clk);
        i_in_valid = 1'b0;
        check("t2_beat33_taken", 256'(o_beat_cnt), 256'(1));
        for (int k = 1; k < BEATS; k++) send_beat(32'hA503_0000 | k, k == BEATS - 1);
        pulse_out_ready(2);
        check("t2_empty", 256'(o_out_valid), 256'(0));

        // Drain coinciding with the final beat of the next row
        send_row(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int k = 0; k < BEATS - 1; k++) send_beat(k == 0 ? 32'h12345678 : 32'h0, 1'b0);
        i_out_ready = 1'b1;
        send_beat(32'h0, 1'b1);
        i_out_ready = 1'b0;
        check("t3_valid", 256'(o_out_valid), 256'(1));
        check("t3_no_stall", 256'(o_in_ready), 256'(1));
        check("t3_cam", 256'(o_cam_data), {16'h1357, 240'h0});
        pulse_out_ready(1);

        // Early last on beat 5, then a clean row
        for (int k = 0; k <= 5; k++) send_beat(32'h5555_5555, k == 5);
        check("t4_err", 256'(o_err_frame), 256'(1));
        check("t4_cnt", 256'(o_beat_cnt), 256'(0));
        check("t4_no_valid", 256'(o_out_valid), 256'(0));
        send_row(32'h87654321, 32'h0);
        check("t4_row_cam", 256'(o_cam_data), {16'h8642, 240'h0});
        check("t4_row_cim", 256'(o_cim_data), {16'h7531, 240'h0});

        // Clear at beat 7 with the hold bank valid
        for (int k = 0; k < 7; k++) send_beat(32'h3333_3333, 1'b0);
        i_clear = 1'b1; i_in_valid = 1'b1; i_in_data = 32'h7777_7777;
        @(negedge i_clk);
        i_clear = 1'b0; i_in_valid = 1'b0;
        check("t5_valid", 256'(o_out_valid), 256'(0));
        check("t5_cnt", 256'(o_beat_cnt), 256'(0));
        check("t5_err", 256'(o_err_frame), 256'(0));
        check("t5_ready", 256'(o_in_ready), 256'(1));
        check("t5_data_kept", 256'(o_cam_data), {16'h8642, 240'h0});

        // Async reset while stalled
        send_row(32'h1111_1111, 32'h2222_2222);
        send_row(32'h4444_4444, 32'h0);
        check("t6_stalled", 256'(o_in_ready), 256'(0));
        #2 i_rst_n = 1'b0;
        #1;
        check("t6_in_ready", 256'(o_in_ready), 256'(0));
        check("t6_valid", 256'(o_out_valid), 256'(0));
        check("t6_cam", 256'(o_cam_data), 256'(0));
        check("t6_cim", 256'(o_cim_data), 256'(0));
        #1 i_rst_n = 1'b1;
        @(negedge i_clk);
        check("t6_ready_after", 256'(o_in_ready), 256'(1));

        // Re-parametrised instance: 4 beats of 64 bits, 128-bit rows
        for (int k = 0; k < 4; k++) begin
            b_in_valid = 1'b1;
            b_in_data  = (k == 0) ? 64'h0123_4567_89AB_CDEF : 64'h0;
            b_in_last  = (k == 3);
            check("p_ready", 256'(b_in_ready), 256'(1));
            @(negedge i_clk);
        end
        b_in_valid = 1'b0; b_in_last = 1'b0;
        check("p_valid", 256'(b_out_valid), 256'(1));
        check("p_cam", 256'(b_cam), 256'({32'h0246_8ACE, 96'h0}));
        check("p_cim", 256'(b_cim), 256'({32'h1357_9BDF, 96'h0}));
        check("p_cnt", 256'(b_cnt), 256'(0));
        check("p_err", 256'(b_err), 256'(0));

        repeat (2) @(negedge i_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
